// File: rtl/victim_cache_wb.sv
// Fully-associative victim cache behind the L1.5 data array.
// S1 lookup/write/invalidate with registered S2 result, S3 insert, and a one-entry buffer that drains dirty victims.
module victim_cache_wb #(
   parameter int ADDR_WIDTH  = 36,
   parameter int DATA_WIDTH  = 128,
   parameter int NUM_ENTRIES = 16,
   parameter int IDX_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  l15_vc_val_s1,
   input  logic [1:0]            l15_vc_op_s1,
   input  logic [ADDR_WIDTH-1:0] l15_vc_addr_s1,
   input  logic [DATA_WIDTH-1:0] l15_vc_mask_s1,
   input  logic [DATA_WIDTH-1:0] l15_vc_wdata_s1,
   output logic                  vc_l15_hit_s2,
   output logic [IDX_WIDTH-1:0]  vc_l15_index_s2,
   output logic [1:0]            vc_l15_mesi_s2,
   output logic [DATA_WIDTH-1:0] vc_l15_data_s2,
   input  logic                  l15_vc_ins_val_s3,
   output logic                  vc_l15_ins_rdy_s3,
   input  logic [ADDR_WIDTH-1:0] l15_vc_ins_addr_s3,
   input  logic [1:0]            l15_vc_ins_mesi_s3,
   input  logic [DATA_WIDTH-1:0] l15_vc_ins_data_s3,
   output logic                  vc_wb_val,
   input  logic                  l15_wb_rdy,
   output logic [ADDR_WIDTH-1:0] vc_wb_addr,
   output logic [DATA_WIDTH-1:0] vc_wb_data,
   output logic [IDX_WIDTH:0]    vc_count
);
   localparam int CW = IDX_WIDTH + 1;
   localparam logic [1:0] MESI_I = 2'b00, MESI_M = 2'b11;
   localparam logic [1:0] OP_READ = 2'b00, OP_WRITE = 2'b01, OP_INVAL = 2'b10;

   logic [1:0]            mesi_q [NUM_ENTRIES];
   logic [1:0]            mesi_d [NUM_ENTRIES];
   logic [ADDR_WIDTH-1:0] addr_q [NUM_ENTRIES];
   logic [ADDR_WIDTH-1:0] addr_d [NUM_ENTRIES];
   logic [DATA_WIDTH-1:0] data_q [NUM_ENTRIES];
   logic [DATA_WIDTH-1:0] data_d [NUM_ENTRIES];
   logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
   logic                  wb_val_q, wb_val_d;
   logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
   logic                  hit_s2_q, hit_s2_d;
   logic [IDX_WIDTH-1:0]  idx_s2_q, idx_s2_d;
   logic [1:0]            mesi_s2_q, mesi_s2_d;
   logic [DATA_WIDTH-1:0] data_s2_q, data_s2_d;
   logic [CW-1:0]         count_q, count_d;

   logic                  ins_wr, ins_same, has_free, ins_evict, ins_to_free;
   logic [IDX_WIDTH-1:0]  same_idx, free_idx, ins_slot;
   logic [NUM_ENTRIES-1:0] match_vec;
   logic                  s1_hit, inval_hit;
   logic [IDX_WIDTH-1:0]  s1_idx;
   logic [DATA_WIDTH-1:0] merged;

   assign vc_l15_ins_rdy_s3 = !wb_val_q;
   assign ins_wr = l15_vc_ins_val_s3 && !wb_val_q && (l15_vc_ins_mesi_s3 != MESI_I);

   // Insert slot: resident same-addr entry, else lowest free, else round-robin victim
   always_comb begin
      ins_same = 1'b0;
      same_idx = '0;
      has_free = 1'b0;
      free_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (mesi_q[i] != MESI_I && addr_q[i] == l15_vc_ins_addr_s3) begin
            ins_same = 1'b1;
            same_idx = IDX_WIDTH'(i);
         end
         if (mesi_q[i] == MESI_I) begin
            has_free = 1'b1;
            free_idx = IDX_WIDTH'(i);
         end
      end
      ins_slot    = ins_same ? same_idx : (has_free ? free_idx : rr_ptr_q);
      ins_evict   = ins_wr && !ins_same && !has_free;
      ins_to_free = ins_wr && !ins_same && has_free;
   end

   always_comb begin
      s1_hit = 1'b0;
      s1_idx = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         match_vec[i] = l15_vc_val_s1 && (mesi_q[i] != MESI_I) && (addr_q[i] == l15_vc_addr_s1)
                        && !(ins_wr && ins_slot == IDX_WIDTH'(i));
         if (match_vec[i]) begin
            s1_hit = 1'b1;
            s1_idx = IDX_WIDTH'(i);
         end
      end
      merged    = (l15_vc_wdata_s1 & l15_vc_mask_s1) | (data_q[s1_idx] & ~l15_vc_mask_s1);
      inval_hit = s1_hit && (l15_vc_op_s1 == OP_INVAL);
   end

   always_comb begin
      mesi_d    = mesi_q;
      addr_d    = addr_q;
      data_d    = data_q;
      rr_ptr_d  = rr_ptr_q;
      wb_val_d  = wb_val_q;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      hit_s2_d  = 1'b0;
      idx_s2_d  = '0;
      mesi_s2_d = MESI_I;
      data_s2_d = '0;
      if (s1_hit && l15_vc_op_s1 != 2'b11) begin
         hit_s2_d = 1'b1;
         idx_s2_d = s1_idx;
         case (l15_vc_op_s1)
            OP_WRITE: begin
               mesi_d[s1_idx] = MESI_M;
               data_d[s1_idx] = merged;
               mesi_s2_d      = MESI_M;
               data_s2_d      = merged;
            end
            OP_INVAL: begin
               mesi_d[s1_idx] = MESI_I;
               mesi_s2_d      = mesi_q[s1_idx];
               data_s2_d      = data_q[s1_idx];
            end
            default: begin
               mesi_s2_d = mesi_q[s1_idx];
               data_s2_d = data_q[s1_idx];
            end
         endcase
      end
      if (wb_val_q && l15_wb_rdy) wb_val_d = 1'b0;
      if (ins_wr) begin
         if (ins_evict) begin
            rr_ptr_d = rr_ptr_q + IDX_WIDTH'(1);
            if (mesi_q[ins_slot] == MESI_M) begin
               wb_val_d  = 1'b1;
               wb_addr_d = addr_q[ins_slot];
               wb_data_d = data_q[ins_slot];
            end
         end
         mesi_d[ins_slot] = l15_vc_ins_mesi_s3;
         addr_d[ins_slot] = l15_vc_ins_addr_s3;
         data_d[ins_slot] = l15_vc_ins_data_s3;
      end
      count_d = count_q + CW'(ins_to_free) - CW'(inval_hit);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            mesi_q[i] <= MESI_I;
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         rr_ptr_q  <= '0;
         wb_val_q  <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         hit_s2_q  <= 1'b0;
         idx_s2_q  <= '0;
         mesi_s2_q <= MESI_I;
         data_s2_q <= '0;
         count_q   <= '0;
      end else begin
         mesi_q    <= mesi_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         rr_ptr_q  <= rr_ptr_d;
         wb_val_q  <= wb_val_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         hit_s2_q  <= hit_s2_d;
         idx_s2_q  <= idx_s2_d;
         mesi_s2_q <= mesi_s2_d;
         data_s2_q <= data_s2_d;
         count_q   <= count_d;
      end
   end

   // Duplicate resident addresses would mean the insert path is broken
   always_ff @(posedge clk) begin
      if (rst_n) assert ($countones(match_vec) <= 1);
   end

   assign vc_l15_hit_s2   = hit_s2_q;
   assign vc_l15_index_s2 = idx_s2_q;
   assign vc_l15_mesi_s2  = mesi_s2_q;
   assign vc_l15_data_s2  = data_s2_q;
   assign vc_wb_val       = wb_val_q;
   assign vc_wb_addr      = wb_addr_q;
   assign vc_wb_data      = wb_data_q;
   assign vc_count        = count_q;
endmodule

// File: tb/tb_victim_cache_wb.sv
// Bench for victim_cache_wb: directed scenarios, a behavioural cache model compared every cycle,
// and literal expectations that pin the model.
module tb_victim_cache_wb;
   logic          clk = 1'b0;
   logic          rst_n;
   logic          l15_vc_val_s1;
   logic [1:0]    l15_vc_op_s1;
   logic [35:0]   l15_vc_addr_s1;
   logic [127:0]  l15_vc_mask_s1;
   logic [127:0]  l15_vc_wdata_s1;
   logic          vc_l15_hit_s2;
   logic [3:0]    vc_l15_index_s2;
   logic [1:0]    vc_l15_mesi_s2;
   logic [127:0]  vc_l15_data_s2;
   logic          l15_vc_ins_val_s3;
   logic          vc_l15_ins_rdy_s3;
   logic [35:0]   l15_vc_ins_addr_s3;
   logic [1:0]    l15_vc_ins_mesi_s3;
   logic [127:0]  l15_vc_ins_data_s3;
   logic          vc_wb_val;
   logic          l15_wb_rdy;
   logic [35:0]   vc_wb_addr;
   logic [127:0]  vc_wb_data;
   logic [4:0]    vc_count;

   int n_cmp = 0;
   int n_bad = 0;

   victim_cache_wb dut (
      .clk(clk), .rst_n(rst_n),
      .l15_vc_val_s1(l15_vc_val_s1), .l15_vc_op_s1(l15_vc_op_s1), .l15_vc_addr_s1(l15_vc_addr_s1),
      .l15_vc_mask_s1(l15_vc_mask_s1), .l15_vc_wdata_s1(l15_vc_wdata_s1),
      .vc_l15_hit_s2(vc_l15_hit_s2), .vc_l15_index_s2(vc_l15_index_s2),
      .vc_l15_mesi_s2(vc_l15_mesi_s2), .vc_l15_data_s2(vc_l15_data_s2),
      .l15_vc_ins_val_s3(l15_vc_ins_val_s3), .vc_l15_ins_rdy_s3(vc_l15_ins_rdy_s3),
      .l15_vc_ins_addr_s3(l15_vc_ins_addr_s3), .l15_vc_ins_mesi_s3(l15_vc_ins_mesi_s3),
      .l15_vc_ins_data_s3(l15_vc_ins_data_s3),
      .vc_wb_val(vc_wb_val), .l15_wb_rdy(l15_wb_rdy), .vc_wb_addr(vc_wb_addr),
      .vc_wb_data(vc_wb_data), .vc_count(vc_count)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a table of lines plus a writeback slot
   logic [1:0]   m_st [16];
   logic [35:0]  m_ad [16];
   logic [127:0] m_dt [16];
   int           m_ptr;
   bit           e_wb_val;
   logic [35:0]  e_wb_addr;
   logic [127:0] e_wb_data;
   bit           e_hit;
   int           e_idx;
   logic [1:0]   e_mesi;
   logic [127:0] e_data;
   int           e_count;
   bit           model_ok = 0;

   always @(posedge clk) begin
      int  slot, hit_i;
      bit  wr, evict;
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin m_st[i] = 0; m_ad[i] = 0; m_dt[i] = 0; end
         m_ptr = 0; e_wb_val = 0; e_wb_addr = 0; e_wb_data = 0;
         e_hit = 0; e_idx = 0; e_mesi = 0; e_data = 0; e_count = 0;
      end else begin
         wr = l15_vc_ins_val_s3 && !e_wb_val && l15_vc_ins_mesi_s3 != 2'b00;
         slot = -1; evict = 0;
         if (wr) begin
            for (int i = 0; i < 16; i++)
               if (m_st[i] != 0 && m_ad[i] == l15_vc_ins_addr_s3) slot = i;
            if (slot < 0)
               for (int i = 15; i >= 0; i--) if (m_st[i] == 0) slot = i;
            if (slot < 0) begin slot = m_ptr; evict = 1; end
         end
         hit_i = -1;
         if (l15_vc_val_s1 && l15_vc_op_s1 != 2'b11)
            for (int i = 0; i < 16; i++)
               if (m_st[i] != 0 && m_ad[i] == l15_vc_addr_s1 && i != slot) hit_i = i;
         e_hit = 0; e_idx = 0; e_mesi = 0; e_data = 0;
         if (hit_i >= 0) begin
            e_hit = 1; e_idx = hit_i;
            e_mesi = m_st[hit_i]; e_data = m_dt[hit_i];
            if (l15_vc_op_s1 == 2'b01) begin
               m_dt[hit_i] = (l15_vc_wdata_s1 & l15_vc_mask_s1) | (m_dt[hit_i] & ~l15_vc_mask_s1);
               m_st[hit_i] = 2'b11;
               e_mesi = 2'b11; e_data = m_dt[hit_i];
            end else if (l15_vc_op_s1 == 2'b10) begin
               m_st[hit_i] = 0;
            end
         end
         if (e_wb_val && l15_wb_rdy) e_wb_val = 0;
         if (wr) begin
            if (evict) begin
               if (m_st[slot] == 2'b11) begin
                  e_wb_val = 1; e_wb_addr = m_ad[slot]; e_wb_data = m_dt[slot];
               end
               m_ptr = (m_ptr + 1) % 16;
            end
            m_st[slot] = l15_vc_ins_mesi_s3;
            m_ad[slot] = l15_vc_ins_addr_s3;
            m_dt[slot] = l15_vc_ins_data_s3;
         end
         e_count = 0;
         for (int i = 0; i < 16; i++) if (m_st[i] != 0) e_count++;
      end
      model_ok = 1;
   end

   always @(negedge clk) begin
      if (model_ok) begin
         cmp("m_hit", 128'(vc_l15_hit_s2), 128'(e_hit));
         cmp("m_idx", 128'(vc_l15_index_s2), 128'(e_idx[3:0]));
         cmp("m_mesi", 128'(vc_l15_mesi_s2), 128'(e_mesi));
         cmp("m_data", vc_l15_data_s2, e_data);
         cmp("m_wb_val", 128'(vc_wb_val), 128'(e_wb_val));
         if (e_wb_val) begin
            cmp("m_wb_addr", 128'(vc_wb_addr), 128'(e_wb_addr));
            cmp("m_wb_data", vc_wb_data, e_wb_data);
         end
         cmp("m_rdy", 128'(vc_l15_ins_rdy_s3), 128'(!e_wb_val));
         cmp("m_count", 128'(vc_count), 128'(e_count));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      l15_vc_val_s1 = 0; l15_vc_op_s1 = 0; l15_vc_addr_s1 = 0;
      l15_vc_mask_s1 = 0; l15_vc_wdata_s1 = 0;
      l15_vc_ins_val_s3 = 0; l15_vc_ins_addr_s3 = 0; l15_vc_ins_mesi_s3 = 0; l15_vc_ins_data_s3 = 0;
   endtask

   task automatic s1(input logic [1:0] op, input logic [35:0] a, input logic [127:0] m, input logic [127:0] w);
      l15_vc_val_s1 = 1; l15_vc_op_s1 = op; l15_vc_addr_s1 = a; l15_vc_mask_s1 = m; l15_vc_wdata_s1 = w;
   endtask

   task automatic ins(input logic [35:0] a, input logic [1:0] st, input logic [127:0] d);
      l15_vc_ins_val_s3 = 1; l15_vc_ins_addr_s3 = a; l15_vc_ins_mesi_s3 = st; l15_vc_ins_data_s3 = d;
   endtask

   localparam logic [127:0] D_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] D_B = 128'h0BBB_0000_0000_0000_0000_0000_0000_0B0B;
   localparam logic [127:0] D_AW = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32AB;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 0; l15_wb_rdy = 0;
      idle();
      repeat (2) tick();
      cmp("rst_count", 128'(vc_count), 128'd0);
      cmp("rst_rdy", 128'(vc_l15_ins_rdy_s3), 128'd1);
      cmp("rst_wb_val", 128'(vc_wb_val), 128'd0);
      cmp("rst_hit", 128'(vc_l15_hit_s2), 128'd0);
      rst_n = 1;

      // basic inserts and read
      ins(36'h10, 2'b10, D_A); tick();
      ins(36'h20, 2'b11, D_B); tick();
      idle();
      cmp("t1_count", 128'(vc_count), 128'd2);
      s1(2'b00, 36'h20, 0, 0); tick(); idle();
      cmp("t1_hit", 128'(vc_l15_hit_s2), 128'd1);
      cmp("t1_idx", 128'(vc_l15_index_s2), 128'd1);
      cmp("t1_mesi", 128'(vc_l15_mesi_s2), 128'd3);
      cmp("t1_data", vc_l15_data_s2, D_B);

      // masked write
      s1(2'b01, 36'h10, 128'hFF, 128'hAB); tick(); idle();
      cmp("t2_mesi", 128'(vc_l15_mesi_s2), 128'd3);
      cmp("t2_data", vc_l15_data_s2, D_AW);

      // fill and evict dirty slot 0
      for (int i = 2; i < 16; i++) begin
         ins(36'h100 + 36'(i), 2'b01, 128'(i)); tick();
      end
      idle();
      cmp("t3_full", 128'(vc_count), 128'd16);
      ins(36'h999, 2'b10, 128'h999); tick(); idle();
      cmp("t3_wb_val", 128'(vc_wb_val), 128'd1);
      cmp("t3_wb_addr", 128'(vc_wb_addr), 128'h10);
      cmp("t3_wb_data", vc_wb_data, D_AW);
      ins(36'h777, 2'b01, 128'h777);
      for (int k = 0; k < 3; k++) begin
         tick();
         cmp("t3_hold_val", 128'(vc_wb_val), 128'd1);
         cmp("t3_hold_rdy", 128'(vc_l15_ins_rdy_s3), 128'd0);
         cmp("t3_hold_addr", 128'(vc_wb_addr), 128'h10);
      end
      idle(); l15_wb_rdy = 1; tick(); l15_wb_rdy = 0;
      cmp("t3_drain_val", 128'(vc_wb_val), 128'd0);
      cmp("t3_drain_rdy", 128'(vc_l15_ins_rdy_s3), 128'd1);
      cmp("t3_count", 128'(vc_count), 128'd16);

      // insert into pointer slot while reading its old addr
      ins(36'hAAA, 2'b01, 128'hAAA); s1(2'b00, 36'h20, 0, 0); tick(); idle();
      cmp("t4_hit", 128'(vc_l15_hit_s2), 128'd0);
      cmp("t4_wb_addr", 128'(vc_wb_addr), 128'h20);
      l15_wb_rdy = 1;
      s1(2'b00, 36'hAAA, 0, 0); tick(); idle();
      cmp("t4_hit_new", 128'(vc_l15_hit_s2), 128'd1);
      cmp("t4_idx_new", 128'(vc_l15_index_s2), 128'd1);

      // invalidate a dirty line
      s1(2'b01, 36'h999, {128{1'b1}}, 128'hDEAD_BEEF); tick();
      s1(2'b10, 36'h999, 0, 0); tick(); idle();
      cmp("t5_hit", 128'(vc_l15_hit_s2), 128'd1);
      cmp("t5_mesi", 128'(vc_l15_mesi_s2), 128'd3);
      cmp("t5_data", vc_l15_data_s2, 128'hDEAD_BEEF);
      s1(2'b00, 36'h999, 0, 0); tick(); idle();
      cmp("t5_miss", 128'(vc_l15_hit_s2), 128'd0);
      cmp("t5_count", 128'(vc_count), 128'd15);

      // same-addr insert over a dirty line
      s1(2'b01, 36'h102, 0, 0); tick();
      idle(); ins(36'h102, 2'b10, 128'h5A5A); tick(); idle();
      cmp("t6_wb_val", 128'(vc_wb_val), 128'd0);
      cmp("t6_count", 128'(vc_count), 128'd15);
      s1(2'b00, 36'h102, 0, 0); tick(); idle();
      cmp("t6_idx", 128'(vc_l15_index_s2), 128'd2);
      cmp("t6_mesi", 128'(vc_l15_mesi_s2), 128'd2);
      cmp("t6_data", vc_l15_data_s2, 128'h5A5A);

      // reserved op, dropped insert, parallel insert and write
      s1(2'b11, 36'h102, 0, 0); tick(); idle();
      cmp("x_reserved", 128'(vc_l15_hit_s2), 128'd0);
      ins(36'h555, 2'b00, 128'h555); tick(); idle();
      cmp("x_drop", 128'(vc_count), 128'd15);
      ins(36'h666, 2'b01, 128'h666); s1(2'b01, 36'h103, 128'hF, 128'h5); tick(); idle();
      cmp("x_par_idx", 128'(vc_l15_index_s2), 128'd3);
      cmp("x_par_data", vc_l15_data_s2, 128'h5);
      cmp("x_par_count", 128'(vc_count), 128'd16);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
